dmem_port_arbiter: RTL

Shares the single data-memory port of the single-cycle RISC-V core between the core's load/store path and a DMA/program-loader requester. Core accesses get same-cycle combinational grant so the single-cycle datapath is unchanged when uncontended. The DMA side gets locked bursts, a starvation guard and registered read-data return. A lost arbitration raises `core_stall`, which drives the PC register `Load` low and gates `RegWrite`/`MemWrite` for that cycle.

---
 rtl/riscv_pkg.sv | 7 +
 rtl/dmem_port_arbiter_if.sv | 23 ++
 rtl/dmem_arb_starve_ctr.sv | 16 +
 rtl/dmem_port_arbiter.sv | 51 +++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types and default datapath widths
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ADDR_W = XLEN;
  localparam int DATA_W = XLEN;
  typedef enum logic {IDLE, DMA_BURST} arb_state_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: core, DMA and data-memory port signals around the arbiter
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = riscv_pkg::ADDR_W,
  parameter int DATA_W = riscv_pkg::DATA_W
);
  logic core_req, core_we, core_gnt, core_stall;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd, mem_rd;
  modport slave (
    input core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_last, dma_addr, dma_wdata, mem_rd,
    output core_gnt, core_stall, core_rdata, dma_gnt, dma_rdata, dma_rvalid, mem_we, mem_addr, mem_wd
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata, dma_req, dma_we, dma_last, dma_addr, dma_wdata, mem_rd,
    input core_gnt, core_stall, core_rdata, dma_gnt, dma_rdata, dma_rvalid, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating count of consecutive denied DMA cycles
module dmem_arb_starve_ctr #(
  parameter int LIMIT = 8,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_limit
);
  assign at_limit = cnt == W'(LIMIT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clr ? '0 : at_limit ? cnt : cnt + W'(1);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between core and DMA; DMEM_ARB_BURST_EN enables locked DMA bursts
module dmem_port_arbiter import riscv_pkg::*; #(
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  dmem_port_arbiter_if.slave bus
);
`ifdef DMEM_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  arb_state_t state, state_d;
  logic [CW-1:0] starve_cnt;
  logic starve_at_limit, dma_force, dma_rd;
  dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .reset(reset),
    .clr(~bus.dma_req | dma_force),
    .cnt(starve_cnt),
    .at_limit(starve_at_limit)
  );
  // grants are gated by reset so nothing reaches memory while it is held
  assign dma_force = reset & bus.dma_req & ((state == DMA_BURST) | starve_at_limit | ~bus.core_req);
  assign bus.dma_gnt = dma_force;
  assign bus.core_gnt = reset & bus.core_req & ~dma_force;
  assign bus.core_stall = bus.core_req & ~bus.core_gnt;
  assign bus.mem_addr = dma_force ? bus.dma_addr : bus.core_addr;
  assign bus.mem_wd = dma_force ? bus.dma_wdata : bus.core_wdata;
  assign bus.mem_we = (bus.core_gnt & bus.core_we) | (dma_force & bus.dma_we);
  assign bus.core_rdata = bus.mem_rd;
  assign dma_rd = dma_force & ~bus.dma_we;
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? ((BURST_EN & dma_force & ~bus.dma_last) ? DMA_BURST : IDLE)
                              : (((dma_force & bus.dma_last) | ~bus.dma_req) ? IDLE : DMA_BURST);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bus.dma_rvalid <= 1'b0;
      bus.dma_rdata <= '0;
    end else begin
      state <= state_d;
      bus.dma_rvalid <= dma_rd;
      if (dma_rd) bus.dma_rdata <= bus.mem_rd;
    end
  assert property (@(posedge clk) disable iff (!reset) starve_cnt <= CW'(STARVE_LIMIT));
endmodule
